// File: rtl/mem_burst_reader_pkg.sv
// Shared types and sizing for the burst read sequencer.
package mem_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// Two-entry FIFO holding returned words tagged with their last flag.
module rd_fifo2
   import mem_burst_reader_pkg::*;
#(
   parameter int W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0] mem [FIFO_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read sequencer: issues addresses to a synchronous-read memory and
// streams the returned words out over valid/ready with a last marker.
module mem_burst_reader
   import mem_burst_reader_pkg::*;
#(
   parameter int BITS         = 8,
   parameter int ADDRESS_SIZE = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDRESS_SIZE-1:0] base_addr,
   input  logic [ADDRESS_SIZE:0]   length,
   output logic                    busy,
   output logic                    done,
   output logic [ADDRESS_SIZE-1:0] mem_address,
   input  logic [BITS-1:0]         mem_data,
   output logic [BITS-1:0]         out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last
);

   state_t                  state_q, state_d;
   logic                    done_d;
   logic [ADDRESS_SIZE-1:0] addr_q;
   logic [ADDRESS_SIZE:0]   rem_issue_q;
   logic [ADDRESS_SIZE:0]   rem_out_q;
   logic                    inflight;
   logic                    inflight_last;
   logic                    issue;
   logic                    issue_last;
   logic                    pop;
   logic                    accept;
   logic [CNT_W-1:0]        fifo_count;
   logic [CNT_W:0]          credit_used;

   assign pop    = out_valid && out_ready;
   assign accept = (state_q == IDLE) && start && (length != '0);

   // Words already owed to the FIFO after this edge; must stay below depth.
   assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}
                        - {{CNT_W{1'b0}}, pop};
   assign issue       = (state_q == READ) && (rem_issue_q != '0)
                        && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
   assign issue_last  = (rem_issue_q == (ADDRESS_SIZE+1)'(1));

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) state_d = READ;
               else              done_d  = 1'b1;
            end
         end
         READ: begin
            if (issue && issue_last) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && rem_out_q == (ADDRESS_SIZE+1)'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q        <= '0;
         rem_issue_q   <= '0;
         rem_out_q     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && issue_last;
         if (accept) begin
            addr_q      <= base_addr;
            rem_issue_q <= length;
            rem_out_q   <= length;
         end else begin
            if (issue) begin
               addr_q      <= addr_q + 1'b1;
               rem_issue_q <= rem_issue_q - 1'b1;
            end
            if (pop && rem_out_q != '0) rem_out_q <= rem_out_q - 1'b1;
         end
      end
   end

   rd_fifo2 #(.W(BITS + 1)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .pop   (pop),
      .din   ({inflight_last, mem_data}),
      .dout  ({out_last, out_data}),
      .count (fifo_count)
   );

   assign out_valid   = (fifo_count != '0);
   assign busy        = (state_q != IDLE);
   assign mem_address = addr_q;

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
Burst read sequencer that sits directly upstream of the synchronous-read memory. It drives the memory address port and absorbs its one-cycle read latency. It returns the fetched words as a valid/ready stream with a last marker. One start command reads `length` consecutive words from `base_addr`, and addresses wrap modulo 2**ADDRESS_SIZE.

Parameters:
BITS, 8, data word width; must match the memory's `bits`.
ADDRESS_SIZE, 4, memory address width; must match the memory's `address_size`.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  command strobe, sampled only in IDLE
base_addr  input  ADDRESS_SIZE  first word address
length  input  ADDRESS_SIZE+1  number of words to read (0 allowed)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at burst completion
mem_address  output  ADDRESS_SIZE  to memory address input; driven directly from a register
mem_data  input  BITS  from memory dataOut; valid the cycle after an address issue
out_data  output  BITS  stream data
out_valid  output  1  stream valid
out_ready  input  1  stream ready
out_last  output  1  high with the final word of a burst

Behaviour:
- Reset (async, any time including mid-burst):
  - state=IDLE; busy, done, out_valid, out_last=0; out_data=0; mem_address=0.
  - FIFO emptied; in-flight flag cleared, so the mem_data arriving next cycle is discarded.
- States:
  - IDLE:
    - start && length!=0: latch addr=base_addr, remaining_issue=length, remaining_out=length; go to READ.
    - start && length==0: done=1 for the next cycle only, stay in IDLE, no stream output.
  - READ:
    - Issue one address per cycle while credit allows.
    - On the issue of the last address, go to DRAIN.
  - DRAIN:
    - No further issues.
    - When the handshake of the word with out_last completes, go to IDLE with done=1 for one cycle.
  - start is ignored outside IDLE.
- Issue rule:
  - issue = (state==READ) && remaining_issue!=0 && (fifo_count + inflight - pop) < 2.
  - pop = out_valid && out_ready.
  - mem_address holds the register value; on issue the register increments, wrapping from 2**ADDRESS_SIZE-1 to 0.
  - inflight <= issue.
- Capture: if inflight, mem_data is pushed into the 2-entry FIFO at the next edge. The credit rule guarantees no push into a full FIFO.
- Stream:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - Data and last are stable while out_valid && !out_ready.
  - out_last = head is the word for which remaining_out==1.
- Latency: with the start-sampling edge E0, the first address is presented after E0, memory data appears after E1, and out_valid rises after E2.
- Throughput: with out_ready held at 1, one word per cycle, no bubbles.
- Simultaneous push and pop: count unchanged.
- Lengths above 2**ADDRESS_SIZE: addresses keep wrapping and words repeat.

Decomposition:
- Package mem_burst_reader_pkg:
  - state_t enum {IDLE, READ, DRAIN};
  - localparam FIFO_DEPTH=2.
- Sub-module rd_fifo2: 2-entry FIFO parameterised on BITS+1 bits (data plus last), with push/pop, count output and async reset.

Test Plan:
All scenarios use BITS=8 and ADDRESS_SIZE=4 against the memory preloaded with ram[i]=i, so data equals address.
1. After reset, start with base=0, len=4, out_ready=1 -> out_data 0,1,2,3 on 4 consecutive cycles starting E0+2; out_last with 3; done one cycle after the last handshake; busy falls with done.
2. base=14, len=4 -> mem_address 14,15,0,1; out_data 14,15,0,1; out_last with 1.
3. base=3, len=6, out_ready pattern 1,0,0,1,0,1,1,1 -> exactly 3..8 delivered in order, none dropped or duplicated; out_data stable during stalls; fifo_count+inflight never exceeds 2.
4. start with len=0 -> done=1 for exactly one cycle, out_valid never set, busy stays 0.
5. Burst base=0, len=8:
   - start pulsed again while busy -> ignored.
   - rst asserted after 2 handshakes -> all outputs 0 immediately.
   - Then base=5, len=2 -> only 5,6 emitted.
6. base=0, len=16, out_ready=1 -> 16 words in 16 consecutive cycles, values 0..15, single done.
